// File: rtl/cpc_vram_arbiter.sv
// Time-division arbiter for the shared 64 KB video/CPU DRAM: a 16-phase ck16 cycle per microsecond,
// slots 0/1 fetch the CRTC byte pair, slot CPU_SLOT serves one pending Z80 access.
module cpc_vram_arbiter #(
  parameter int CPU_SLOT = 2,
  parameter int CAP_PH   = 2
) (
  input  logic        ck16,
  input  logic        reset_n,
  input  logic [13:0] ma,
  input  logic [4:0]  ra,
  input  logic        dispen,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cclk,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] vid_data,
  output logic        vid_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  localparam logic [3:0] GRANT_PH    = 4'(CPU_SLOT * 4);
  localparam logic [3:0] CAP0_PH     = 4'(CAP_PH);
  localparam logic [3:0] CAP1_PH     = 4'(CAP_PH + 4);
  localparam logic [1:0] CAP_SUB     = 2'(CAP_PH);
  localparam logic [1:0] CPU_SLOT_ID = 2'(CPU_SLOT);

  state_t      state, state_next;
  logic [3:0]  phase;
  logic [1:0]  slot, sub;
  logic [14:0] vid_base;
  logic        vid_disp;
  logic [7:0]  byte0;
  logic [15:0] lat_addr;
  logic        lat_we;
  logic [7:0]  lat_wdata;
  logic        grant;
  logic        unused_bits;

  assign slot        = phase[3:2];
  assign sub         = phase[1:0];
  assign cclk        = ~phase[3];
  assign mem_wdata   = lat_wdata;
  assign grant       = (state == WAIT) && cpu_req && (phase == GRANT_PH);
  assign unused_bits = ^{ma[11:10], ra[4:3]};

  // Phase counter and video fetch; CRTC inputs are frozen for the whole microsecond at phase 0.
  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= 4'd0;
      vid_base  <= 15'd0;
      vid_disp  <= 1'b0;
      byte0     <= 8'd0;
      vid_data  <= 16'd0;
      vid_valid <= 1'b0;
    end else begin
      phase <= phase + 4'd1;
      if (phase == 4'd0) begin
        vid_base <= {ma[13:12], ra[2:0], ma[9:0]};
        vid_disp <= dispen;
      end
      if (phase == CAP0_PH)
        byte0 <= mem_rdata;
      if (phase == CAP1_PH)
        vid_data <= {mem_rdata, byte0};
      vid_valid <= (phase == CAP1_PH) && vid_disp;
    end
  end

  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // The CPU request is captured on the grant cycle so the Z80 bus may move on afterwards.
  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr  <= 16'd0;
      lat_we    <= 1'b0;
      lat_wdata <= 8'd0;
      cpu_rdata <= 8'd0;
    end else begin
      if (grant) begin
        lat_addr  <= cpu_addr;
        lat_we    <= cpu_we;
        lat_wdata <= cpu_wdata;
      end
      if ((state == ACCESS) && !lat_we && (sub == CAP_SUB))
        cpu_rdata <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    cpu_ready  = 1'b1;
    mem_addr   = 16'd0;

    if (slot == 2'd0)
      mem_addr = {vid_base, 1'b0};
    else if (slot == 2'd1)
      mem_addr = {vid_base, 1'b1};
    else if (slot == CPU_SLOT_ID)
      mem_addr = lat_addr;

    // ACCESS runs to the end of its slot even if the request is withdrawn.
    case (state)
      IDLE: begin
        if (cpu_req)
          state_next = WAIT;
      end
      WAIT: begin
        cpu_ready = 1'b0;
        if (!cpu_req)
          state_next = IDLE;
        else if (phase == GRANT_PH)
          state_next = ACCESS;
      end
      ACCESS: begin
        cpu_ready = 1'b0;
        mem_we    = lat_we && (sub == 2'd1);
        if (sub == 2'd3)
          state_next = DONE;
      end
      DONE: begin
        if (!cpu_req)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpc_vram_arbiter.sv
// Self-checking bench for cpc_vram_arbiter: table-driven video address/data vectors, hand-written
// CPU corner cases and randomized CPU traffic checked against a slot-level reference model.
module tb_cpc_vram_arbiter;

  localparam int GRANT_PH = 8;

  logic        ck16;
  logic        reset_n;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        dispen;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  mem_rdata;
  logic        cclk;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic [15:0] vid_data;
  logic        vid_valid;

  cpc_vram_arbiter #(.CPU_SLOT(2), .CAP_PH(2)) dut (
    .ck16(ck16), .reset_n(reset_n), .ma(ma), .ra(ra), .dispen(dispen),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_rdata(mem_rdata), .cclk(cclk), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .vid_data(vid_data), .vid_valid(vid_valid)
  );

  initial ck16 = 1'b0;
  always #5 ck16 = ~ck16;

  // Synchronous RAM with one cycle of read latency plus a bench-side preload port.
  bit [7:0]    ram  [0:65535];
  bit [7:0]    gold [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge ck16) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        dispen;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] vid;
    logic        valid;
  } vec_t;

  vec_t        vecs [5];
  int          checks;
  int          errors;
  logic [3:0]  mph;
  logic [14:0] exp_base;
  logic        exp_disp;
  bit          armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (phase %0d)", name, act, exp, mph);
    end
  endtask

  // One ck16 cycle; the model phase advances and the per-phase rules are checked at the falling edge.
  task automatic tick();
    if (mph == 4'd0) begin
      exp_base = {ma[13:12], ra[2:0], ma[9:0]};
      exp_disp = dispen;
      armed    = 1'b1;
    end
    @(posedge ck16);
    @(negedge ck16);
    mph = mph + 4'd1;
    check("cclk", cclk, !mph[3]);
    if (armed && mph >= 4'd1 && mph <= 4'd3) check("vid_addr0", mem_addr, {exp_base, 1'b0});
    if (armed && mph >= 4'd5 && mph <= 4'd7) check("vid_addr1", mem_addr, {exp_base, 1'b1});
    if (mph[3:2] == 2'd3) check("spare_slot_addr", mem_addr, 0);
    if (armed && mph == 4'd7) begin
      check("vid_data", vid_data, {gold[{exp_base, 1'b1}], gold[{exp_base, 1'b0}]});
      check("vid_valid", vid_valid, exp_disp);
    end else begin
      check("vid_valid_idle", vid_valid, 0);
    end
  endtask

  task automatic wait_phase(input logic [3:0] p);
    int k = 0;
    while (mph != p && k < 17) begin
      tick();
      k++;
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
    gold[a]  = d;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    mph     = 4'd0;
    armed   = 1'b0;
  endtask

  // Full CPU transaction: latency, read data, write strobe count and hold-after-done behaviour.
  task automatic apply_stimulus(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                                input logic [3:0] start_ph, input int hold, input int drop_at);
    int delta, lat, n, pulses;
    bit done;
    wait_phase(start_ph);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    delta = (GRANT_PH - int'(start_ph)) & 15;
    if (delta == 0) delta = 16;
    lat    = delta + 4;
    n      = 0;
    pulses = 0;
    done   = 1'b0;
    while (!done && n < 40) begin
      if (n == delta) begin
        fork
          begin
            @(posedge ck16);
            #1;
            cpu_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_we    = ~we;
          end
        join_none
      end
      tick();
      n++;
      if (n == 1) check("ready_drops", cpu_ready, 0);
      if (mem_we) begin
        pulses++;
        check("wr_addr", mem_addr, addr);
        check("wr_data", mem_wdata, wd);
      end
      if (drop_at >= 0 && n == drop_at) cpu_req = 1'b0;
      if (cpu_ready) done = 1'b1;
    end
    check("latency", n, lat);
    if (!we) check("rd_data", cpu_rdata, gold[addr]);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("ready_hold", cpu_ready, 1);
      if (!we) check("rd_hold", cpu_rdata, gold[addr]);
      if (mem_we) pulses++;
    end
    cpu_req = 1'b0;
    tick();
    if (mem_we) pulses++;
    tick();
    check("ready_idle", cpu_ready, 1);
    check("we_pulses", pulses, we ? 1 : 0);
    if (we) gold[addr] = wd;
  endtask

  initial begin
    vecs[0] = '{ma:14'h3FFF, ra:5'h07, dispen:1'b1, b0:8'hA5, b1:8'h5A,
                a0:16'hFFFE, a1:16'hFFFF, vid:16'h5AA5, valid:1'b1};
    vecs[1] = '{ma:14'h0000, ra:5'h00, dispen:1'b0, b0:8'h12, b1:8'h34,
                a0:16'h0000, a1:16'h0001, vid:16'h3412, valid:1'b0};
    vecs[2] = '{ma:14'h1234, ra:5'h05, dispen:1'b1, b0:8'h9C, b1:8'hE1,
                a0:16'h6C68, a1:16'h6C69, vid:16'hE19C, valid:1'b1};
    vecs[3] = '{ma:14'h2C00, ra:5'h1A, dispen:1'b0, b0:8'h0F, b1:8'hF0,
                a0:16'h9000, a1:16'h9001, vid:16'hF00F, valid:1'b0};
    vecs[4] = '{ma:14'h03FF, ra:5'h18, dispen:1'b1, b0:8'h81, b1:8'h7E,
                a0:16'h07FE, a1:16'h07FF, vid:16'h7E81, valid:1'b1};

    checks = 0; errors = 0; mph = 4'd0; armed = 1'b0;
    exp_base = 15'd0; exp_disp = 1'b0;
    pre_we = 1'b0; pre_addr = 16'd0; pre_data = 8'd0;
    ma = 14'd0; ra = 5'd0; dispen = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;

    reset_n = 1'b0;
    repeat (3) @(negedge ck16);
    check("rst_cclk", cclk, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_ready", cpu_ready, 1);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_vid_valid", vid_valid, 0);
    release_reset();
    repeat (40) tick();

    for (int i = 0; i < 5; i++) begin
      poke(vecs[i].a0, vecs[i].b0);
      poke(vecs[i].a1, vecs[i].b1);
      ma = vecs[i].ma; ra = vecs[i].ra; dispen = vecs[i].dispen;
      wait_phase(4'd0);
      tick();
      wait_phase(4'd2);
      check("tbl_addr0", mem_addr, vecs[i].a0);
      wait_phase(4'd6);
      check("tbl_addr1", mem_addr, vecs[i].a1);
      wait_phase(4'd7);
      check("tbl_vid_data", vid_data, vecs[i].vid);
      check("tbl_vid_valid", vid_valid, vecs[i].valid);
    end

    poke(16'h1AAA, 8'hC3);
    poke(16'h1AAB, 8'h3C);
    ma = 14'h0155; ra = 5'h03; dispen = 1'b1;

    poke(16'h1234, 8'h96);
    apply_stimulus(1'b0, 16'h1234, 8'h00, 4'd7, 0, -1);
    apply_stimulus(1'b1, 16'h4000, 8'h3C, 4'd8, 0, -1);
    apply_stimulus(1'b0, 16'h4000, 8'h00, 4'd3, 0, -1);
    poke(16'h8123, 8'h5D);
    apply_stimulus(1'b0, 16'h8123, 8'h00, 4'd5, 40, -1);
    apply_stimulus(1'b1, 16'h8200, 8'hE7, 4'd7, 0, 2);
    apply_stimulus(1'b0, 16'h8200, 8'h00, 4'd12, 20, -1);

    // Request withdrawn while still waiting for the slot: no access at all.
    wait_phase(4'd10);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8250; cpu_wdata = 8'hAA;
    tick(); tick(); tick();
    check("wait_ready_low", cpu_ready, 0);
    cpu_req = 1'b0;
    tick();
    check("withdraw_ready", cpu_ready, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mem_we) check("withdraw_no_we", mem_we, 0);
    end
    apply_stimulus(1'b0, 16'h8250, 8'h00, 4'd1, 0, -1);

    for (int i = 0; i < 24; i++) begin
      bit we;
      logic [15:0] a;
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom) | 16'h8000;
      if (!we) poke(a, 8'($urandom));
      apply_stimulus(we, a, 8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3), -1);
    end

    // Reset while the write is waiting at its grant cycle: the write must never reach the RAM.
    poke(16'h8300, 8'h11);
    wait_phase(4'd7);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8300; cpu_wdata = 8'hEE;
    tick();
    check("pre_rst_ready", cpu_ready, 0);
    reset_n = 1'b0;
    #1;
    check("rst_async_ready", cpu_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge ck16);
      check("rst_no_we", mem_we, 0);
    end
    cpu_req = 1'b0;
    release_reset();
    apply_stimulus(1'b0, 16'h8300, 8'h00, 4'd3, 0, -1);

    // Reset asserted mid-read: every output returns to its reset value without a clock edge.
    poke(16'h8400, 8'h77);
    wait_phase(4'd7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8400;
    tick(); tick(); tick();
    check("mid_access_ready", cpu_ready, 0);
    check("mid_access_addr", mem_addr, 16'h8400);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_cclk", cclk, 1);
    check("async_mem_addr", mem_addr, 0);
    check("async_mem_we", mem_we, 0);
    check("async_mem_wdata", mem_wdata, 0);
    check("async_ready", cpu_ready, 1);
    check("async_rdata", cpu_rdata, 0);
    check("async_vid_data", vid_data, 0);
    check("async_vid_valid", vid_valid, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge ck16);
    release_reset();
    repeat (34) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
